// File: rtl/ifu_fetch_if.sv
// Fetch-stage handshake bundle: PC input, instruction-memory bus and decode output.
// master = fetch stage, slave = the surrounding PC logic, memory and decode.
interface ifu_fetch_if #(
  parameter int ADDR_W = 32
);
  logic [ADDR_W-1:0] pc_in;
  logic              pc_in_valid;
  logic              pc_in_ready;
  logic              redirect;
  logic              imem_req_valid;
  logic [ADDR_W-1:0] imem_req_addr;
  logic              imem_req_ready;
  logic              imem_rsp_valid;
  logic [31:0]       imem_rsp_data;
  logic              imem_rsp_err;
  logic [31:0]       inst;
  logic [ADDR_W-1:0] inst_pc;
  logic              inst_valid;
  logic              inst_ready;
  logic              inst_err;

  modport master (
    input  pc_in, pc_in_valid, redirect, imem_req_ready, imem_rsp_valid,
           imem_rsp_data, imem_rsp_err, inst_ready,
    output pc_in_ready, imem_req_valid, imem_req_addr, inst, inst_pc,
           inst_valid, inst_err
  );

  modport slave (
    output pc_in, pc_in_valid, redirect, imem_req_ready, imem_rsp_valid,
           imem_rsp_data, imem_rsp_err, inst_ready,
    input  pc_in_ready, imem_req_valid, imem_req_addr, inst, inst_pc,
           inst_valid, inst_err
  );
endinterface

// File: rtl/ifu_fetch.sv
// Instruction fetch stage: one outstanding imem request, redirect kill, response timeout.
// Min latency pc accept -> inst_valid is 3 cycles; IFU_MISALIGN_CHK_EN faults misaligned PCs locally.
module ifu_fetch #(
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 255,
  parameter int TO_W    = 8
) (
  input  logic        clk,
  input  logic        rst,
  ifu_fetch_if.master bus
);
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [2:0] {IDLE, REQ, WAIT, OUT, DROP} state_t;

  state_t            state;
  logic [ADDR_W-1:0] addr;
  logic [TO_W-1:0]   cnt;
  logic [TO_W-1:0]   cnt_inc;
  logic              pend;
  logic              pc_take;
  logic              req_acc;
  logic              to_fire;
  logic              rsp_done;
  logic              launch;
  logic              launch_mis;
  logic [ADDR_W-1:0] launch_addr;

  // A redirect may carry its new target in the same cycle, except while draining.
  assign bus.pc_in_ready   = !rst && ((state == IDLE) || ((state == OUT) && bus.inst_ready) ||
                                      (bus.redirect && (state != DROP)));
  assign pc_take           = bus.pc_in_valid && bus.pc_in_ready;
  assign req_acc           = bus.imem_req_valid && bus.imem_req_ready;
  assign cnt_inc           = (&cnt) ? cnt : cnt + 1'b1;
  assign to_fire           = (TIMEOUT != 0) && (cnt_inc == TO_W'(TIMEOUT));
  assign rsp_done          = bus.imem_rsp_valid || to_fire;
  assign bus.imem_req_addr = addr;

  // launch: start a fresh fetch this cycle, from pc_in or from the target parked during DROP.
  always_comb begin
    launch      = 1'b0;
    launch_addr = bus.pc_in;
    case (state)
      IDLE:    launch = pc_take;
      REQ:     launch = bus.redirect && !req_acc && pc_take;
      WAIT:    launch = bus.redirect && rsp_done && pc_take;
      OUT:     launch = (bus.redirect || bus.inst_ready) && pc_take;
      DROP: begin
        launch      = rsp_done && pend;
        launch_addr = addr;
      end
      default: launch = 1'b0;
    endcase
  end

`ifdef IFU_MISALIGN_CHK_EN
  assign launch_mis = |launch_addr[1:0];
`else
  assign launch_mis = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state              <= IDLE;
      addr               <= '0;
      cnt                <= '0;
      pend               <= 1'b0;
      bus.imem_req_valid <= 1'b0;
      bus.inst           <= '0;
      bus.inst_pc        <= '0;
      bus.inst_valid     <= 1'b0;
      bus.inst_err       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
        end
        REQ: begin
          if (bus.redirect) begin
            bus.imem_req_valid <= 1'b0;
            if (req_acc) begin
              // The bus already took the request, so its response must still be drained.
              state <= DROP;
              cnt   <= '0;
              pend  <= pc_take;
              if (pc_take) addr <= bus.pc_in;
            end else begin
              state <= IDLE;
            end
          end else if (req_acc) begin
            state              <= WAIT;
            cnt                <= '0;
            bus.imem_req_valid <= 1'b0;
          end
        end
        WAIT: begin
          cnt <= cnt_inc;
          if (bus.redirect) begin
            state <= rsp_done ? IDLE : DROP;
            pend  <= pc_take && !rsp_done;
            if (pc_take) addr <= bus.pc_in;
          end else if (bus.imem_rsp_valid) begin
            state          <= OUT;
            bus.inst       <= bus.imem_rsp_data;
            bus.inst_pc    <= addr;
            bus.inst_err   <= bus.imem_rsp_err;
            bus.inst_valid <= 1'b1;
          end else if (to_fire) begin
            state          <= OUT;
            bus.inst       <= NOP;
            bus.inst_pc    <= addr;
            bus.inst_err   <= 1'b1;
            bus.inst_valid <= 1'b1;
          end
        end
        OUT: begin
          if (bus.redirect || bus.inst_ready) begin
            state          <= IDLE;
            bus.inst_valid <= 1'b0;
          end
        end
        DROP: begin
          cnt <= cnt_inc;
          if (rsp_done) begin
            state <= IDLE;
            pend  <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase

      if (launch) begin
        addr <= launch_addr;
        if (launch_mis) begin
          state              <= OUT;
          bus.imem_req_valid <= 1'b0;
          bus.inst           <= NOP;
          bus.inst_pc        <= launch_addr;
          bus.inst_err       <= 1'b1;
          bus.inst_valid     <= 1'b1;
        end else begin
          state              <= REQ;
          bus.imem_req_valid <= 1'b1;
        end
      end
    end
  end
endmodule
